// File: rtl/aes_link_ctrl_if.sv
// Link bundle between the block sequencer and its neighbours: packets from
// the RS-232 receiver, the 128-bit AES core handshake, and the byte-wide
// serializer handshake. The sequencer takes the slave view; the surrounding
// environment (receiver, AES core, serializer) takes the master view.
interface aes_link_ctrl_if;
  logic [63:0]  rx_data;
  logic         rx_valid;
  logic [127:0] aes_in;
  logic         aes_start;
  logic [127:0] aes_out;
  logic         aes_done;
  logic [7:0]   tx_byte;
  logic         tx_load;
  logic         tx_busy;

  modport master (
    output rx_data, rx_valid, aes_out, aes_done, tx_busy,
    input  aes_in, aes_start, tx_byte, tx_load
  );

  modport slave (
    input  rx_data, rx_valid, aes_out, aes_done, tx_busy,
    output aes_in, aes_start, tx_byte, tx_load
  );
endinterface

// File: rtl/aes_link_ctrl.sv
// aes_link_ctrl: assembles two 64-bit receive packets into one AES block,
// starts the core, captures its result and hands it to the serializer one
// byte at a time (LSB byte first). Watches for a stalled core, a missing
// second packet and packets arriving while the block is occupied; those
// conditions are latched in sticky error flags until reset.
module aes_link_ctrl #(
  parameter int unsigned AES_TIMEOUT = 4096,
  parameter int unsigned GAP_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  aes_link_ctrl_if.slave link,
  output logic          busy,
  output logic [2:0]    err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALF  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  // Counters start at 0 on entry, so the last allowed count is TIMEOUT-1;
  // the timeout fires on the cycle that would have made the count TIMEOUT.
  localparam logic [15:0] AES_LAST = 16'(AES_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

  // Byte k of a 128-bit block lives at bits [8k+7:8k].
  function automatic logic [7:0] sel_byte(input logic [127:0] blk, input logic [3:0] k);
    return blk[{k, 3'b000} +: 8];
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [15:0]    gap_cnt_q, gap_cnt_d;
  logic [15:0]    aes_cnt_q, aes_cnt_d;
  logic [127:0]   aes_in_q, aes_in_d;
  logic [127:0]   result_q, result_d;
  logic           aes_start_q, aes_start_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_load_q, tx_load_d;
  logic           busy_q, busy_d;
  logic [2:0]     err_q, err_d;

  // Next-state, datapath and registered-output lookahead for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    aes_cnt_d   = aes_cnt_q;
    aes_in_d    = aes_in_q;
    result_d    = result_q;
    tx_byte_d   = tx_byte_q;
    tx_load_d   = 1'b0;
    err_d       = err_q;
    aes_start_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (link.rx_valid) begin
          aes_in_d[63:0] = link.rx_data;
          gap_cnt_d      = 16'd0;
          state_d        = S_HALF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALF: begin
        // A packet in the expiry cycle still wins over the timeout.
        if (link.rx_valid) begin
          aes_in_d[127:64] = link.rx_data;
          state_d          = S_START;
        end else if (gap_cnt_q == GAP_LAST) begin
          err_d[2] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_START: begin
        aes_cnt_d = 16'd0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A result in the expiry cycle still wins over the timeout.
        if (link.aes_done) begin
          result_d = link.aes_out;
          idx_d    = 4'd0;
          state_d  = S_SEND;
        end else if (aes_cnt_q == AES_LAST) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          aes_cnt_d = aes_cnt_q + 16'd1;
        end
      end
      S_SEND: begin
        if (!link.tx_busy) begin
          tx_load_d = 1'b1;
          tx_byte_d = sel_byte(result_q, idx_q);
          state_d   = S_HOLD;
        end else begin
          state_d = S_SEND;
        end
      end
      S_HOLD: begin
        // Blanking cycle: the serializer may not have raised busy yet.
        if (idx_q == 4'd15) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Packets are only accepted while assembling; anything later is dropped.
    if (link.rx_valid && (state_q != S_IDLE) && (state_q != S_HALF)) begin
      err_d[1] = 1'b1;
    end else begin
      err_d[1] = err_d[1];
    end

    // Outputs are registered, so they are derived from the upcoming state.
    aes_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      gap_cnt_q   <= 16'd0;
      aes_cnt_q   <= 16'd0;
      aes_in_q    <= 128'd0;
      result_q    <= 128'd0;
      aes_start_q <= 1'b0;
      tx_byte_q   <= 8'd0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      aes_cnt_q   <= aes_cnt_d;
      aes_in_q    <= aes_in_d;
      result_q    <= result_d;
      aes_start_q <= aes_start_d;
      tx_byte_q   <= tx_byte_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign link.aes_in    = aes_in_q;
  assign link.aes_start = aes_start_q;
  assign link.tx_byte   = tx_byte_q;
  assign link.tx_load   = tx_load_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule
